// File: rtl/fetch_seq_if.sv
// Instruction-memory fetch channel: req/ready request handshake plus an
// rvalid/rdata response that may arrive with the accept or later.
interface fetch_seq_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_seq.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches one instruction at a
// time, pulses reg_we for the single EXEC cycle and halts sticky on ebreak.
// Optional build macro FETCH_TIMEOUT_EN adds a FETCH+WAIT stall timeout that
// parks the sequencer in a sticky error state.
module fetch_seq #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          PC_STEP     = 4,
    parameter int          TIMEOUT_CYC = 255,
    parameter int          TIMEOUT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    fetch_seq_if.master        imem,
    input  logic               jump_en,
    input  logic [31:0]        jump_tgt,
    output logic [31:0]        inst,
    output logic [31:0]        pc,
    output logic               reg_we,
    output logic               halt,
    output logic               err
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT, S_ERR
    } state_t;

    state_t state_q, state_n;
    logic   timeout_hit;

    // Counter must be able to hold the terminal count.
    if (TIMEOUT_CYC >= (1 << TIMEOUT_W)) begin : g_bad_cfg
        $error("fetch_seq: TIMEOUT_CYC does not fit in TIMEOUT_W bits");
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_n;
    end

    // Next-state logic; a completed fetch wins over a coincident timeout.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:  state_n = S_FETCH;
            S_FETCH: begin
                if (imem.ready && imem.rvalid) state_n = S_EXEC;
                else if (timeout_hit)          state_n = S_ERR;
                else if (imem.ready)           state_n = S_WAIT;
            end
            S_WAIT: begin
                if (imem.rvalid)      state_n = S_EXEC;
                else if (timeout_hit) state_n = S_ERR;
            end
            S_EXEC:  state_n = (inst == EBREAK) ? S_HALT : S_FETCH;
            S_HALT:  state_n = S_HALT;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decode registered state/inst only, so no input reaches them combinationally.
    always_comb begin
        imem.req = 1'b0;
        reg_we   = 1'b0;
        case (state_q)
            S_FETCH: imem.req = 1'b1;
            S_EXEC:  reg_we   = (inst != EBREAK);
            default: ;
        endcase
    end

    assign imem.addr = pc;

    // PC, instruction latch and sticky halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc   <= RESET_PC;
            inst <= '0;
            halt <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (imem.ready && imem.rvalid) inst <= imem.rdata;
                S_WAIT:  if (imem.rvalid)               inst <= imem.rdata;
                S_EXEC: begin
                    if (inst == EBREAK) halt <= 1'b1;
                    else if (jump_en)   pc   <= {jump_tgt[31:2], 2'b00};
                    else                pc   <= pc + 32'(PC_STEP);
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 err_q;

    // Timeout fires on the cycle whose increment would reach TIMEOUT_CYC.
    assign timeout_hit = (cnt_q == TO_LAST);
    assign err         = err_q;

    // Stall counter across FETCH+WAIT; cleared whenever the fetch completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == S_FETCH || state_q == S_WAIT) && state_n != S_EXEC)
                cnt_q <= cnt_q + 1'b1;
            else
                cnt_q <= '0;
            if (state_n == S_ERR) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Randomized bench for fetch_seq: the bench plays instruction memory and keeps a
// transaction-level model (expected PC, last delivered word, request/outstanding flags).
module tb_fetch_seq;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_tgt = '0;
    logic [31:0] inst, pc;
    logic        reg_we, halt, err;

    fetch_seq_if imem_if ();

    fetch_seq dut (
        .clk      (clk),
        .rst      (rst),
        .imem     (imem_if),
        .jump_en  (jump_en),
        .jump_tgt (jump_tgt),
        .inst     (inst),
        .pc       (pc),
        .reg_we   (reg_we),
        .halt     (halt),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model of what the sequencer should be doing, in transaction terms.
    logic [31:0] m_pc, m_inst, m_data;
    bit          m_want_req, m_out, m_exec, m_halt;
    int          halt_cycles;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Reset pulse; stale rvalid is driven during reset and in the IDLE cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_if.ready  = 1'b0;
        imem_if.rvalid = 1'($urandom % 2);
        imem_if.rdata  = $urandom;
        jump_en        = 1'($urandom % 2);
        #1;
        chk("rst_req",    32'(imem_if.req), 0);
        chk("rst_reg_we", 32'(reg_we), 0);
        chk("rst_pc",     pc, RESET_PC);
        chk("rst_inst",   inst, 0);
        chk("rst_halt",   32'(halt), 0);
        chk("rst_err",    32'(err), 0);
        @(negedge clk);
        chk("rst_hold_req", 32'(imem_if.req), 0);
        rst = 1'b1;
        imem_if.rvalid = 1'b1;
        imem_if.ready  = 1'($urandom % 2);
        imem_if.rdata  = $urandom;
        m_pc = RESET_PC; m_inst = '0; m_data = '0;
        m_want_req = 1'b1; m_out = 1'b0; m_exec = 1'b0; m_halt = 1'b0;
        halt_cycles = 0;
    endtask

    task automatic deliver();
        imem_if.rvalid = 1'b1;
        imem_if.rdata  = ($urandom % 30 == 0) ? EBREAK : $urandom;
        m_data = imem_if.rdata;
        m_inst = imem_if.rdata;
    endtask

    // One cycle: check what the DUT shows, then pick inputs and advance the model.
    task automatic step();
        bit nx;
        @(negedge clk);
        chk("req", 32'(imem_if.req), 32'(m_want_req));
        if (imem_if.req) chk("addr", imem_if.addr, m_pc);
        chk("reg_we", 32'(reg_we), 32'(m_exec && (m_data != EBREAK)));
        chk("pc",   pc, m_pc);
        chk("inst", inst, m_inst);
        chk("halt", 32'(halt), 32'(m_halt));
        chk("err",  32'(err), 0);

        nx = 1'b0;
        imem_if.ready  = 1'b0;
        imem_if.rvalid = 1'b0;
        imem_if.rdata  = $urandom;
        jump_en        = ($urandom % 4 == 0);
        jump_tgt       = ($urandom % 3 == 0) ? 32'hFFFF_FFFF :
                         ($urandom % 2 == 0) ? 32'h8000_0103 : $urandom;

        if (m_exec) begin
            if (m_data == EBREAK) m_halt = 1'b1;
            else begin
                m_pc = jump_en ? (jump_tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
                m_want_req = 1'b1;
            end
        end else if (m_want_req) begin
            imem_if.ready = ($urandom % 3 != 0);
            if (imem_if.ready) begin
                m_want_req = 1'b0;
                if ($urandom % 2 == 0) begin deliver(); nx = 1'b1; end
                else m_out = 1'b1;
            end else begin
                imem_if.rvalid = 1'($urandom % 2);
            end
        end else if (m_out) begin
            if ($urandom % 3 == 0) begin deliver(); nx = 1'b1; m_out = 1'b0; end
        end else begin
            imem_if.ready  = 1'($urandom % 2);
            imem_if.rvalid = 1'($urandom % 2);
        end
        m_exec = nx;
        if (m_halt) halt_cycles++;
    endtask

    initial begin
        imem_if.ready  = 1'b0;
        imem_if.rvalid = 1'b0;
        imem_if.rdata  = '0;

        // Stall with ready held low straight out of reset.
        do_reset();
`ifdef FETCH_TIMEOUT_EN
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            chk("to_req", 32'(imem_if.req), 1);
            chk("to_err_early", 32'(err), 0);
            imem_if.ready = 1'b0; imem_if.rvalid = 1'b0;
        end
        @(negedge clk);
        chk("to_err", 32'(err), 1);
        chk("to_req_off", 32'(imem_if.req), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("to_no_req", 32'(imem_if.req), 0);
            chk("to_err_sticky", 32'(err), 1);
            chk("to_no_we", 32'(reg_we), 0);
        end
`else
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_if.req), 1);
            chk("stall_addr", imem_if.addr, RESET_PC);
            chk("stall_err", 32'(err), 0);
            imem_if.ready = 1'b0; imem_if.rvalid = 1'($urandom % 2);
        end
`endif

        // Randomized run with random resets and reset-after-halt.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ((m_halt && halt_cycles >= 20) || ($urandom % 250 == 0)) do_reset();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
